branch_rs: RTL and testbench
============================

# branch_rs

Reservation station for control-flow instructions (BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR). It sits between the dispatcher and the branch execution unit. It buffers up to `DEPTH` dispatched instructions and snoops two CDB broadcast ports to resolve pending source operands. Each cycle it issues at most one fully-ready entry, as a one-cycle registered pulse, to the branch execution unit.

## Interface
- `DEPTH`, 8: number of entries; power of two, 2..16.
- `IDX_W`, 3: log2(`DEPTH`).

- `clk_in`  in  1  clock, rising edge.
- `rst_in`  in  1  reset; asynchronous, active-low.
- `rdy_in`  in  1  global ready; low = stall.
- `clear_in`  in  1  misprediction flush, synchronous.
- `disp_valid`  in  1  dispatch request.
- `disp_op`  in  `OPBus`  opcode.
- `disp_q1_valid` / `disp_q2_valid`  in  1  operand 1/2 still pending on a ROB tag.
- `disp_q1` / `disp_q2`  in  `TagBus`  producer tag of operand 1/2.
- `disp_v1` / `disp_v2`  in  `DataBus`  value of operand 1/2, used when not pending.
- `disp_imm`  in  `DataBus`  immediate.
- `disp_pc`  in  `AddressBus`  instruction PC.
- `disp_dest_rob`  in  `TagBus`  destination ROB tag.
- `cdb0_valid`, `cdb1_valid`  in  1  broadcast valid.
- `cdb0_tag`, `cdb1_tag`  in  `TagBus`  broadcast tag.
- `cdb0_data`, `cdb1_data`  in  `DataBus`  broadcast value.
- `full`  out  1  no free entry, combinational from registered occupancy.
- `issue_enable`  out  1  one-cycle issue pulse to the branch unit.
- `issue_op`  out  `OPBus`  opcode of the issued entry.
- `issue_reg1`, `issue_reg2`  out  `DataBus`  resolved operand values.
- `issue_imm`  out  `DataBus`  immediate.
- `issue_pc`  out  `AddressBus`  instruction PC.
- `issue_dest_rob`  out  `TagBus`  destination ROB tag.

## Operation
- Each entry holds: busy, op, q1_valid, q1, v1, q2_valid, q2, v2, imm, pc, dest_rob.
- Dispatch:
  - Accepted when `disp_valid` & !`full` & `rdy_in` & !`clear_in`.
  - The data is written into the lowest-index free entry.
  - A dispatch attempted while `full` is dropped silently. This is a dispatcher protocol violation, and the bench flags it.
- Dispatch-time forwarding: if a pending operand tag equals a valid CDB tag in the same cycle, the entry stores the CDB data with q_valid=0.
  - If both CDB ports match the same tag, cdb0 wins.
- Snoop: every busy entry with q_valid=1 and q equal to a valid CDB tag captures that data and clears q_valid. Both operands may resolve in the same cycle, from either port.
- Ready means busy & !q1_valid & !q2_valid, evaluated on registered state. An entry captured at edge N is eligible at edge N+1.
- Issue: when `rdy_in` & !`clear_in` and at least one entry is ready:
  - select one entry, register its fields onto the `issue_*` outputs, and assert `issue_enable` for exactly one cycle;
  - clear that entry's busy bit at the same edge.
- When no entry issues, `issue_enable`=0 and the other `issue_*` outputs hold their last values.
- An issue and a dispatch in the same cycle are both performed. The freed slot becomes available from the next cycle.
- `clear_in`: at the next edge, all busy bits are cleared and `issue_enable` goes to 0. Any dispatch or issue in that cycle is discarded.
- `rdy_in` low: entry state, occupancy and snoop are all frozen, and `issue_enable` is driven to 0 at the next edge.

## Timing
- Reset (`rst_in`=0, asynchronous): all busy=0 and `full`=0. `issue_enable`=0 and all other `issue_*` outputs are 0, including `issue_op`=`Null`.
- Latency from dispatch of an entry with both operands ready to `issue_enable`: one edge. Dispatch at edge N gives issue at edge N+1.
- Latency from a CDB broadcast resolving the last pending operand to issue: one edge after capture.
- Throughput: one issue per cycle.
- `full` asserts in the cycle after the edge that fills the last entry. It deasserts in the cycle after an issue or a clear.
- Reset asserted mid-operation: the block immediately returns to the reset state. An in-flight `issue_enable` drops asynchronously.

## Configuration
- `BRANCH_RS_AGE_ORDER_EN` defined:
  - each entry carries an age rank, updated on dispatch and issue;
  - issue selects the oldest ready entry, i.e. the one dispatched earliest.
- `BRANCH_RS_AGE_ORDER_EN` undefined: issue selects the lowest-index ready entry, and no age state is built.

## Test plan
- Reset, then dispatch a BEQ with v1=5, v2=5, both ready, pc=0x100, dest_rob=3 -> next edge `issue_enable`=1 with `issue_reg1`=5, `issue_reg2`=5, `issue_pc`=0x100, `issue_dest_rob`=3. The cycle after, `issue_enable`=0.
- Dispatch a BNE with q1=7 pending; two cycles later `cdb1_valid`=1, tag=7, data=0x2A -> issue one edge after capture with `issue_reg1`=0x2A. No issue before the capture.
- Dispatch with q2=4 pending in the same cycle that `cdb0` broadcasts tag=4, data=9 -> the entry is stored ready and issues at the next edge with `issue_reg2`=9.
- Fill all 8 entries with pending operands -> `full`=1, and a 9th dispatch is dropped. Then resolve one entry -> it issues and `full` drops the cycle after.
- Load 3 pending entries, then pulse `clear_in` together with a dispatch -> `issue_enable` stays 0, and occupancy becomes 0 with the dispatch discarded. Separately, drive `rst_in` low mid-run -> outputs return to 0 asynchronously.
- Dispatch entries A then B into slots 2 then 0, and resolve both in the same cycle:
  - with `BRANCH_RS_AGE_ORDER_EN`, A issues first;
  - without it, B (slot 0) issues first.

Source files
------------

// File: rtl/branch_rs.sv
// Reservation station for branch/jump instructions: buffers dispatched entries, snoops two CDB ports, issues one ready entry per cycle.
// Define BRANCH_RS_AGE_ORDER_EN to issue the oldest ready entry instead of the lowest-index one.
module branch_rs #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int OP_W   = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              disp_valid,
    input  logic [OP_W-1:0]   disp_op,
    input  logic              disp_q1_valid,
    input  logic              disp_q2_valid,
    input  logic [TAG_W-1:0]  disp_q1,
    input  logic [TAG_W-1:0]  disp_q2,
    input  logic [DATA_W-1:0] disp_v1,
    input  logic [DATA_W-1:0] disp_v2,
    input  logic [DATA_W-1:0] disp_imm,
    input  logic [ADDR_W-1:0] disp_pc,
    input  logic [TAG_W-1:0]  disp_dest_rob,
    input  logic              cdb0_valid,
    input  logic              cdb1_valid,
    input  logic [TAG_W-1:0]  cdb0_tag,
    input  logic [TAG_W-1:0]  cdb1_tag,
    input  logic [DATA_W-1:0] cdb0_data,
    input  logic [DATA_W-1:0] cdb1_data,
    output logic              full,
    output logic              issue_enable,
    output logic [OP_W-1:0]   issue_op,
    output logic [DATA_W-1:0] issue_reg1,
    output logic [DATA_W-1:0] issue_reg2,
    output logic [DATA_W-1:0] issue_imm,
    output logic [ADDR_W-1:0] issue_pc,
    output logic [TAG_W-1:0]  issue_dest_rob
);

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic              q1v;
        logic [TAG_W-1:0]  q1;
        logic [DATA_W-1:0] v1;
        logic              q2v;
        logic [TAG_W-1:0]  q2;
        logic [DATA_W-1:0] v2;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] pc;
        logic [TAG_W-1:0]  rob;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    entry_t            new_ent;
    logic [DEPTH-1:0]  busy_vec;
    logic [DEPTH-1:0]  ready_vec;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              do_disp;
    logic              do_issue;

    logic              iss_en_q;
    entry_t            iss_q;

    // cdb0 takes precedence when both ports carry the same tag
    function automatic logic [DATA_W:0] resolve(input logic qv, input logic [TAG_W-1:0] q,
                                                input logic [DATA_W-1:0] v);
        if (qv && cdb0_valid && q == cdb0_tag) return {1'b0, cdb0_data};
        if (qv && cdb1_valid && q == cdb1_tag) return {1'b0, cdb1_data};
        return {qv, v};
    endfunction

    always_comb begin
        logic found;
        found    = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy & ~ent_q[i].q1v & ~ent_q[i].q2v;
            if (!found && !ent_q[i].busy) begin
                found    = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign full     = &busy_vec;
    assign do_disp  = disp_valid & ~full & rdy_in & ~clear_in;
    assign do_issue = rdy_in & ~clear_in & (|ready_vec);

`ifdef BRANCH_RS_AGE_ORDER_EN
    // rank = number of older busy entries; ranks of busy entries stay dense 0..occ-1
    localparam logic [IDX_W-1:0] RANK_ONE = IDX_W'(1);
    logic [IDX_W-1:0] rank_q [DEPTH];
    logic [IDX_W-1:0] rank_d [DEPTH];
    logic [IDX_W:0]   occ;

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] best;
        found   = 1'b0;
        best    = '0;
        sel_idx = '0;
        occ     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ = occ + (IDX_W+1)'(busy_vec[i]);
            if (ready_vec[i] && (!found || rank_q[i] < best)) begin
                found   = 1'b1;
                best    = rank_q[i];
                sel_idx = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rank_d[i] = rank_q[i];
            if (do_issue && rank_q[i] > rank_q[sel_idx]) rank_d[i] = rank_q[i] - RANK_ONE;
        end
        if (do_disp) rank_d[free_idx] = IDX_W'(occ - (IDX_W+1)'(do_issue));
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) rank_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) rank_q[i] <= rank_d[i];
        end
    end
`else
    always_comb begin
        logic found;
        found   = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && ready_vec[i]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        new_ent      = '0;
        new_ent.busy = 1'b1;
        new_ent.op   = disp_op;
        new_ent.q1   = disp_q1;
        new_ent.q2   = disp_q2;
        new_ent.imm  = disp_imm;
        new_ent.pc   = disp_pc;
        new_ent.rob  = disp_dest_rob;
        {new_ent.q1v, new_ent.v1} = resolve(disp_q1_valid, disp_q1, disp_v1);
        {new_ent.q2v, new_ent.v2} = resolve(disp_q2_valid, disp_q2, disp_v2);

        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (rdy_in && ent_q[i].busy) begin
                {ent_d[i].q1v, ent_d[i].v1} = resolve(ent_q[i].q1v, ent_q[i].q1, ent_q[i].v1);
                {ent_d[i].q2v, ent_d[i].v2} = resolve(ent_q[i].q2v, ent_q[i].q2, ent_q[i].v2);
            end
        end
        if (do_issue) ent_d[sel_idx].busy = 1'b0;
        if (do_disp)  ent_d[free_idx] = new_ent;
        if (clear_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            iss_en_q <= 1'b0;
            iss_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            iss_en_q <= do_issue;
            if (do_issue) iss_q <= ent_q[sel_idx];
        end
    end

    assign issue_enable   = iss_en_q;
    assign issue_op       = iss_q.op;
    assign issue_reg1     = iss_q.v1;
    assign issue_reg2     = iss_q.v2;
    assign issue_imm      = iss_q.imm;
    assign issue_pc       = iss_q.pc;
    assign issue_dest_rob = iss_q.rob;

endmodule

// File: tb/tb_branch_rs.sv
// Self-checking bench for branch_rs: directed scenarios plus random traffic against a slot/sequence-number model.
module tb_branch_rs;
    localparam int DEPTH = 8, IDX_W = 3, OP_W = 4, TAG_W = 4, DATA_W = 32, ADDR_W = 32;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in, clear_in, disp_valid, disp_q1_valid, disp_q2_valid;
    logic [OP_W-1:0]   disp_op;
    logic [TAG_W-1:0]  disp_q1, disp_q2, disp_dest_rob, cdb0_tag, cdb1_tag;
    logic [DATA_W-1:0] disp_v1, disp_v2, disp_imm, cdb0_data, cdb1_data;
    logic [ADDR_W-1:0] disp_pc;
    logic              cdb0_valid, cdb1_valid;
    logic              full, issue_enable;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_reg1, issue_reg2, issue_imm;
    logic [ADDR_W-1:0] issue_pc;
    logic [TAG_W-1:0]  issue_dest_rob;

    always #5 clk_in = ~clk_in;

    branch_rs #(.DEPTH(DEPTH), .IDX_W(IDX_W), .OP_W(OP_W), .TAG_W(TAG_W),
                .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_q1_valid(disp_q1_valid), .disp_q2_valid(disp_q2_valid),
        .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_dest_rob(disp_dest_rob),
        .cdb0_valid(cdb0_valid), .cdb1_valid(cdb1_valid),
        .cdb0_tag(cdb0_tag), .cdb1_tag(cdb1_tag),
        .cdb0_data(cdb0_data), .cdb1_data(cdb1_data),
        .full(full), .issue_enable(issue_enable), .issue_op(issue_op),
        .issue_reg1(issue_reg1), .issue_reg2(issue_reg2), .issue_imm(issue_imm),
        .issue_pc(issue_pc), .issue_dest_rob(issue_dest_rob)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: slots with a dispatch sequence number for age ordering
    bit                m_busy [DEPTH];
    bit                m_q1v [DEPTH], m_q2v [DEPTH];
    logic [TAG_W-1:0]  m_q1 [DEPTH], m_q2 [DEPTH], m_rob [DEPTH];
    logic [DATA_W-1:0] m_v1 [DEPTH], m_v2 [DEPTH], m_imm [DEPTH];
    logic [ADDR_W-1:0] m_pc [DEPTH];
    logic [OP_W-1:0]   m_op [DEPTH];
    int                m_seq [DEPTH];
    int                seq_ctr;
    bit                e_en;
    logic [OP_W-1:0]   e_op;
    logic [DATA_W-1:0] e_r1, e_r2, e_imm;
    logic [ADDR_W-1:0] e_pc;
    logic [TAG_W-1:0]  e_rob;

    function automatic bit m_full();
        for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        seq_ctr = 0;
        e_en = 0; e_op = '0; e_r1 = '0; e_r2 = '0; e_imm = '0; e_pc = '0; e_rob = '0;
    endtask

    task automatic snoop(input bit qv, input logic [TAG_W-1:0] q, input logic [DATA_W-1:0] v,
                         output bit qv_o, output logic [DATA_W-1:0] v_o);
        qv_o = qv; v_o = v;
        if (qv && cdb0_valid && cdb0_tag == q) begin qv_o = 0; v_o = cdb0_data; end
        else if (qv && cdb1_valid && cdb1_tag == q) begin qv_o = 0; v_o = cdb1_data; end
    endtask

    task automatic model_step();
        int pick, slot;
        bit was_full;
        was_full = m_full();
        if (clear_in) begin
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            e_en = 0;
            return;
        end
        if (!rdy_in) begin
            e_en = 0;
            return;
        end
        slot = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_busy[i]) slot = i;
        pick = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i] && !m_q1v[i] && !m_q2v[i]) begin
`ifdef BRANCH_RS_AGE_ORDER_EN
                if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        e_en = (pick >= 0);
        if (pick >= 0) begin
            e_op = m_op[pick]; e_r1 = m_v1[pick]; e_r2 = m_v2[pick];
            e_imm = m_imm[pick]; e_pc = m_pc[pick]; e_rob = m_rob[pick];
            m_busy[pick] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i]) begin
                snoop(m_q1v[i], m_q1[i], m_v1[i], m_q1v[i], m_v1[i]);
                snoop(m_q2v[i], m_q2[i], m_v2[i], m_q2v[i], m_v2[i]);
            end
        end
        if (disp_valid) begin
            if (was_full) begin
                $display("NOTE: dispatcher protocol violation, dispatch while full dropped at %0t", $time);
            end else begin
                m_busy[slot] = 1'b1;
                m_op[slot] = disp_op; m_q1[slot] = disp_q1; m_q2[slot] = disp_q2;
                m_imm[slot] = disp_imm; m_pc[slot] = disp_pc; m_rob[slot] = disp_dest_rob;
                snoop(disp_q1_valid, disp_q1, disp_v1, m_q1v[slot], m_v1[slot]);
                snoop(disp_q2_valid, disp_q2, disp_v2, m_q2v[slot], m_v2[slot]);
                m_seq[slot] = seq_ctr;
                seq_ctr++;
            end
        end
    endtask

    task automatic compare_all();
        chk_eq("full", full, m_full());
        chk_eq("issue_enable", issue_enable, e_en);
        chk_eq("issue_op", issue_op, e_op);
        chk_eq("issue_reg1", issue_reg1, e_r1);
        chk_eq("issue_reg2", issue_reg2, e_r2);
        chk_eq("issue_imm", issue_imm, e_imm);
        chk_eq("issue_pc", issue_pc, e_pc);
        chk_eq("issue_dest_rob", issue_dest_rob, e_rob);
    endtask

    task automatic step();
        model_step();
        @(posedge clk_in);
        #1;
        compare_all();
    endtask

    task automatic idle();
        rdy_in = 1; clear_in = 0; disp_valid = 0;
        disp_op = '0; disp_q1_valid = 0; disp_q2_valid = 0; disp_q1 = '0; disp_q2 = '0;
        disp_v1 = '0; disp_v2 = '0; disp_imm = '0; disp_pc = '0; disp_dest_rob = '0;
        cdb0_valid = 0; cdb1_valid = 0; cdb0_tag = '0; cdb1_tag = '0; cdb0_data = '0; cdb1_data = '0;
    endtask

    task automatic disp(input int op, input bit a1, input int t1, input int v1,
                        input bit a2, input int t2, input int v2, input int pc, input int rob);
        disp_valid = 1; disp_op = OP_W'(op);
        disp_q1_valid = a1; disp_q1 = TAG_W'(t1); disp_v1 = DATA_W'(v1);
        disp_q2_valid = a2; disp_q2 = TAG_W'(t2); disp_v2 = DATA_W'(v2);
        disp_pc = ADDR_W'(pc); disp_imm = DATA_W'(pc) ^ 32'h5A5A_0000; disp_dest_rob = TAG_W'(rob);
    endtask

    task automatic cdb(input int port, input int tag, input int data);
        if (port == 0) begin cdb0_valid = 1; cdb0_tag = TAG_W'(tag); cdb0_data = DATA_W'(data); end
        else begin cdb1_valid = 1; cdb1_tag = TAG_W'(tag); cdb1_data = DATA_W'(data); end
    endtask

    initial begin
        idle();
        model_reset();
        #12 rst_in = 1;
        compare_all();
        chk_eq("rst_issue_enable", issue_enable, 0);
        chk_eq("rst_full", full, 0);

        // Both operands ready: issue one edge after dispatch
        disp(1, 0, 0, 5, 0, 0, 5, 'h100, 3); step();
        chk_eq("t1_no_early_issue", issue_enable, 0);
        idle(); step();
        chk_eq("t1_en", issue_enable, 1);
        chk_eq("t1_reg1", issue_reg1, 5);
        chk_eq("t1_reg2", issue_reg2, 5);
        chk_eq("t1_pc", issue_pc, 'h100);
        chk_eq("t1_rob", issue_dest_rob, 3);
        step();
        chk_eq("t1_pulse_end", issue_enable, 0);

        // Pending operand resolved by cdb1
        disp(2, 1, 7, 0, 0, 0, 3, 'h104, 4); step();
        idle(); step(); chk_eq("t2_wait_a", issue_enable, 0);
        step(); chk_eq("t2_wait_b", issue_enable, 0);
        cdb(1, 7, 'h2A); step(); chk_eq("t2_capture_no_issue", issue_enable, 0);
        idle(); step();
        chk_eq("t2_en", issue_enable, 1);
        chk_eq("t2_reg1", issue_reg1, 'h2A);

        // Dispatch-time forwarding from cdb0
        disp(3, 0, 0, 1, 1, 4, 0, 'h108, 5); cdb(0, 4, 9); step();
        idle(); step();
        chk_eq("t3_en", issue_enable, 1);
        chk_eq("t3_reg2", issue_reg2, 9);

        // Fill every slot, then overflow
        for (int k = 0; k < DEPTH; k++) begin
            disp(4, 1, k, 0, 0, 0, k, 'h200 + 4 * k, k); step();
        end
        chk_eq("t4_full", full, 1);
        disp(4, 0, 0, 1, 0, 0, 1, 'h300, 9); step();
        chk_eq("t4_drop_full", full, 1);
        chk_eq("t4_drop_no_issue", issue_enable, 0);
        idle(); cdb(0, 5, 'h55); step();
        chk_eq("t4_still_full", full, 1);
        idle(); step();
        chk_eq("t4_en", issue_enable, 1);
        chk_eq("t4_pc", issue_pc, 'h214);
        chk_eq("t4_full_drop", full, 0);

        // Flush with a concurrent dispatch
        clear_in = 1; step(); idle();
        chk_eq("t5_empty", full, 0);
        for (int k = 0; k < 3; k++) begin
            disp(5, 1, 15, 0, 0, 0, 0, 'h400 + 4 * k, k); step();
        end
        idle(); clear_in = 1; disp(6, 0, 0, 1, 0, 0, 2, 'h500, 6); step();
        chk_eq("t5_clear_no_issue", issue_enable, 0);
        idle(); step();
        chk_eq("t5_disp_discarded", issue_enable, 0);
        cdb(0, 15, 'h77); step(); idle(); step();
        chk_eq("t5_cleared_no_issue", issue_enable, 0);

        // Asynchronous reset drops an in-flight issue pulse
        disp(7, 0, 0, 8, 0, 0, 9, 'h600, 7); step();
        idle(); step();
        chk_eq("t5r_pre_en", issue_enable, 1);
        #1 rst_in = 0;
        #1;
        chk_eq("async_en", issue_enable, 0);
        chk_eq("async_op", issue_op, 0);
        chk_eq("async_pc", issue_pc, 0);
        chk_eq("async_full", full, 0);
        model_reset();
        #1 rst_in = 1;

        // Age ordering: A in slot 2, B in slot 0, resolved together
        disp(1, 1, 10, 0, 0, 0, 0, 'h900, 1); step();
        disp(1, 1, 11, 0, 0, 0, 0, 'h904, 2); step();
        disp(1, 1, 12, 0, 0, 0, 0, 'hA00, 3); step();
        idle(); cdb(0, 10, 1); step();
        idle(); step();
        chk_eq("t6_x0_pc", issue_pc, 'h900);
        disp(1, 1, 13, 0, 0, 0, 0, 'hB00, 4); step();
        idle(); cdb(0, 12, 'hAA); cdb(1, 13, 'hBB); step();
        idle(); step();
`ifdef BRANCH_RS_AGE_ORDER_EN
        chk_eq("t6_first_pc", issue_pc, 'hA00);
        step();
        chk_eq("t6_second_pc", issue_pc, 'hB00);
`else
        chk_eq("t6_first_pc", issue_pc, 'hB00);
        step();
        chk_eq("t6_second_pc", issue_pc, 'hA00);
`endif
        chk_eq("t6_second_en", issue_enable, 1);
        clear_in = 1; step(); idle();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rdy_in        = ($urandom_range(0, 9) != 0);
            clear_in      = ($urandom_range(0, 59) == 0);
            disp_valid    = !m_full() && ($urandom_range(0, 1) == 1);
            disp_op       = OP_W'($urandom_range(1, 8));
            disp_q1_valid = $urandom_range(0, 1);
            disp_q2_valid = $urandom_range(0, 1);
            disp_q1       = TAG_W'($urandom_range(0, 7));
            disp_q2       = TAG_W'($urandom_range(0, 7));
            disp_v1       = $urandom;
            disp_v2       = $urandom;
            disp_imm      = $urandom;
            disp_pc       = $urandom;
            disp_dest_rob = TAG_W'($urandom_range(0, 15));
            cdb0_valid    = ($urandom_range(0, 2) == 0);
            cdb1_valid    = ($urandom_range(0, 2) == 0);
            cdb0_tag      = TAG_W'($urandom_range(0, 7));
            cdb1_tag      = TAG_W'($urandom_range(0, 7));
            cdb0_data     = $urandom;
            cdb1_data     = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
